// File: rtl/gaussian_nb_llh_accum.sv
// gaussian_nb_llh_accum
//   Consumes the signed product stream of the Gaussian naive-Bayes datapath.
//   Each product is arithmetically shifted right by SHIFT. The shifted values
//   are summed per class over NUM_FEATURES beats, and the running arg-max is
//   tracked. After the last class of a frame, the winning class index and its
//   score are presented on a valid/ready output.
//
//   Optional feature macro: GAUSSIAN_NB_LLH_SAT_EN
//     defined   : saturating accumulation, sticky out_sat flag per frame
//     undefined : two's-complement wrap-around, out_sat tied to 0
//
// Ports
//   clk        clock, rising edge
//   reset      synchronous active-high reset
//   ce         clock enable; when low, all state is frozen
//   in_valid   product beat valid
//   in_ready   beat accepted (high only while accumulating)
//   in_data    signed product, class-major order
//   out_valid  result valid, held until accepted
//   out_ready  downstream accepts result
//   out_class  winning class index
//   out_score  winning class sum
//   out_sat    some class sum saturated during this frame
module gaussian_nb_llh_accum #(
    parameter int NUM_CLASSES  = 4,
    parameter int NUM_FEATURES = 8,
    parameter int PROD_WIDTH   = 35,
    parameter int SHIFT        = 8,
    parameter int ACC_WIDTH    = 40,
    parameter int CLASS_W      = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ce,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [PROD_WIDTH-1:0] in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [CLASS_W-1:0]          out_class,
    output logic signed [ACC_WIDTH-1:0] out_score,
    output logic                        out_sat
);

    localparam int FEAT_W = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;

    typedef enum logic [1:0] {S_ACCUM, S_DRAIN, S_OUT} state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [FEAT_W-1:0]           r_feat_cnt;
    logic [CLASS_W-1:0]          r_cls_cnt;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic signed [ACC_WIDTH-1:0] r_done_sum;
    logic [CLASS_W-1:0]          r_done_cls;
    logic                        r_done_vld;
    logic signed [ACC_WIDTH-1:0] r_best_score;
    logic [CLASS_W-1:0]          r_best_cls;
    logic                        r_sat;

    logic                        w_in_xfer;
    logic                        w_out_xfer;
    logic                        w_last_feat;
    logic                        w_last_cls;
    logic signed [PROD_WIDTH-1:0] w_shifted;
    logic signed [ACC_WIDTH-1:0] w_term;
    logic signed [ACC_WIDTH-1:0] w_acc_add;
    logic signed [ACC_WIDTH-1:0] w_acc_nxt;
    logic                        w_clip;
    logic                        w_take;

    assign w_in_xfer   = in_valid & in_ready & ce;
    assign w_out_xfer  = out_valid & out_ready & ce;
    assign w_last_feat = (r_feat_cnt == FEAT_W'(NUM_FEATURES - 1));
    assign w_last_cls  = (r_cls_cnt == CLASS_W'(NUM_CLASSES - 1));

    // Floor-rounding shift, then sign-extend (or narrow) to accumulator width.
    assign w_shifted = in_data >>> SHIFT;
    assign w_term    = ACC_WIDTH'(w_shifted);

`ifdef GAUSSIAN_NB_LLH_SAT_EN
    // One guard bit detects overflow: top two bits of the extended sum differ.
    function automatic logic signed [ACC_WIDTH:0] add_ext(
        input logic signed [ACC_WIDTH-1:0] a,
        input logic signed [ACC_WIDTH-1:0] b
    );
        return {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
    endfunction

    function automatic logic signed [ACC_WIDTH-1:0] sat_narrow(
        input logic signed [ACC_WIDTH:0] s
    );
        if (s[ACC_WIDTH] != s[ACC_WIDTH-1])
            return s[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        return s[ACC_WIDTH-1:0];
    endfunction

    logic signed [ACC_WIDTH:0] w_sum_ext;
    assign w_sum_ext = add_ext(r_acc, w_term);
    assign w_acc_add = sat_narrow(w_sum_ext);
    assign w_clip    = (w_sum_ext[ACC_WIDTH] != w_sum_ext[ACC_WIDTH-1]);
`else
    assign w_acc_add = r_acc + w_term;
    assign w_clip    = 1'b0;
`endif

    // The first feature of a class loads; later features add (no clip on load).
    assign w_acc_nxt = (r_feat_cnt == '0) ? w_term : w_acc_add;

    // Class 0 always seeds the best; strict compare keeps ties at lower index.
    assign w_take = r_done_vld && ((r_done_cls == '0) || (r_done_sum > r_best_score));

    // State register plus datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_ACCUM;
            r_feat_cnt   <= '0;
            r_cls_cnt    <= '0;
            r_acc        <= '0;
            r_done_sum   <= '0;
            r_done_cls   <= '0;
            r_done_vld   <= 1'b0;
            r_best_score <= '0;
            r_best_cls   <= '0;
            r_sat        <= 1'b0;
        end else if (ce) begin
            r_state    <= w_state_nxt;
            r_done_vld <= w_in_xfer & w_last_feat;
            if (w_in_xfer) begin
                r_acc <= w_acc_nxt;
                if ((r_feat_cnt != '0) && w_clip)
                    r_sat <= 1'b1;
                if (w_last_feat) begin
                    r_feat_cnt <= '0;
                    r_done_sum <= w_acc_nxt;
                    r_done_cls <= r_cls_cnt;
                    r_cls_cnt  <= w_last_cls ? '0 : r_cls_cnt + 1'b1;
                end else begin
                    r_feat_cnt <= r_feat_cnt + 1'b1;
                end
            end
            if (w_take) begin
                r_best_score <= r_done_sum;
                r_best_cls   <= r_done_cls;
            end
            if (w_out_xfer) begin
                r_feat_cnt <= '0;
                r_cls_cnt  <= '0;
                r_sat      <= 1'b0;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_ACCUM: if (w_in_xfer && w_last_feat && w_last_cls) w_state_nxt = S_DRAIN;
            S_DRAIN: w_state_nxt = S_OUT;
            S_OUT:   if (w_out_xfer) w_state_nxt = S_ACCUM;
            default: w_state_nxt = S_ACCUM;
        endcase
    end

    // Output decode; result fields come straight from the best registers,
    // which cannot change while the result is being presented.
    always_comb begin
        in_ready  = (r_state == S_ACCUM);
        out_valid = (r_state == S_OUT);
        out_class = r_best_cls;
        out_score = r_best_score;
        out_sat   = r_sat;
    end

endmodule

// File: tb/tb_gaussian_nb_llh_accum.sv
module tb_gaussian_nb_llh_accum;

    localparam int NC   = 4;
    localparam int NF   = 2;
    localparam int PW   = 35;
    localparam int SH   = 8;
    localparam int AW   = 40;
    localparam int AW_S = 27;
    localparam int CW   = 2;
`ifdef GAUSSIAN_NB_LLH_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset, ce, in_valid, out_ready, sel;
    logic signed [PW-1:0] in_data;

    logic                   rdy0, ov0, sat0, rdy1, ov1, sat1;
    logic [CW-1:0]          cls0, cls1;
    logic signed [AW-1:0]   score0;
    logic signed [AW_S-1:0] score1;

    logic                 in_ready, out_valid, out_sat;
    logic [CW-1:0]        out_class;
    logic signed [AW-1:0] out_score;

    assign in_ready  = sel ? rdy1 : rdy0;
    assign out_valid = sel ? ov1 : ov0;
    assign out_sat   = sel ? sat1 : sat0;
    assign out_class = sel ? cls1 : cls0;
    assign out_score = sel ? AW'(score1) : score0;

    gaussian_nb_llh_accum #(.NUM_CLASSES(NC), .NUM_FEATURES(NF), .PROD_WIDTH(PW),
                            .SHIFT(SH), .ACC_WIDTH(AW), .CLASS_W(CW)) dut0 (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid & ~sel), .in_ready(rdy0),
        .in_data(in_data), .out_valid(ov0), .out_ready(out_ready & ~sel),
        .out_class(cls0), .out_score(score0), .out_sat(sat0));

    gaussian_nb_llh_accum #(.NUM_CLASSES(NC), .NUM_FEATURES(NF), .PROD_WIDTH(PW),
                            .SHIFT(SH), .ACC_WIDTH(AW_S), .CLASS_W(CW)) dut1 (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid & sel), .in_ready(rdy1),
        .in_data(in_data), .out_valid(ov1), .out_ready(out_ready & sel),
        .out_class(cls1), .out_score(score1), .out_sat(sat1));

    int     errs = 0;
    int     checks = 0;
    longint frame [NC*NF];

    // Reference: per-class sum of floor(p / 2^SH) at the given width, then
    // arg-max with ties to the lowest index.
    function automatic void model(input int accw, input bit sat_en,
                                  output int ecls, output longint escore, output bit esat);
        longint mx, mn, s, t, best;
        mx = (longint'(1) <<< (accw - 1)) - 1;
        mn = -mx - 1;
        esat = 1'b0; ecls = 0; best = 0;
        for (int c = 0; c < NC; c++) begin
            s = 0;
            for (int f = 0; f < NF; f++) begin
                t = frame[c*NF + f] >>> SH;
                if (f == 0) s = t;
                else begin
                    s = s + t;
                    if (sat_en) begin
                        if (s > mx) begin s = mx; esat = 1'b1; end
                        else if (s < mn) begin s = mn; esat = 1'b1; end
                    end else begin
                        s = (s <<< (64 - accw)) >>> (64 - accw);
                    end
                end
            end
            if (c == 0 || s > best) begin best = s; ecls = c; end
        end
        escore = best;
    endfunction

    task automatic send_frame(input bit stall);
        int i = 0;
        int guard = 0;
        while (i < NC*NF && guard < 2000) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = PW'(frame[i]);
            ce       = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (in_ready && ce) i++;
            guard++;
        end
        if (i < NC*NF) begin
            errs++; checks++;
            $display("FAIL send_timeout beats_accepted=%0d required=%0d", i, NC*NF);
        end
        @(negedge clk);
        in_valid = 1'b0;
        ce       = 1'b1;
    endtask

    // Called at the negedge just after the last beat's edge.
    task automatic finish_frame(input string name, input bit hold_bp);
        int ecls; longint escore; bit esat;
        logic [CW-1:0] c0; logic signed [AW-1:0] s0;
        model(sel ? AW_S : AW, sel ? SAT_EN : 1'b0, ecls, escore, esat);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errs++;
            $display("FAIL %s_drain out_valid=%b in_ready=%b required 0/0", name, out_valid, in_ready);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errs++;
            $display("FAIL %s_latency out_valid=%b required 1", name, out_valid);
        end
        checks++;
        if (out_class !== CW'(ecls)) begin
            errs++;
            $display("FAIL %s_class got=%0d required=%0d", name, out_class, ecls);
        end
        checks++;
        if (out_score !== AW'(escore)) begin
            errs++;
            $display("FAIL %s_score got=%0d required=%0d", name, out_score, escore);
        end
        checks++;
        if (out_sat !== esat) begin
            errs++;
            $display("FAIL %s_sat got=%b required=%b", name, out_sat, esat);
        end
        if (hold_bp) begin
            c0 = CW'(ecls); s0 = AW'(escore);
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                checks++;
                if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_class !== c0 || out_score !== s0) begin
                    errs++;
                    $display("FAIL %s_hold cyc=%0d valid=%b ready=%b class=%0d score=%0d required 1/0/%0d/%0d",
                             name, k, out_valid, in_ready, out_class, out_score, c0, s0);
                end
            end
            // out_ready with ce low must not complete the transfer.
            out_ready = 1'b1; ce = 1'b0;
            @(negedge clk);
            ce = 1'b1;
            checks++;
            if (out_valid !== 1'b1) begin
                errs++;
                $display("FAIL %s_ce_hold out_valid=%b required 1", name, out_valid);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errs++;
            $display("FAIL %s_release out_valid=%b in_ready=%b required 0/1", name, out_valid, in_ready);
        end
    endtask

    task automatic set_frame(input longint p0, p1, p2, p3, p4, p5, p6, p7);
        frame[0] = p0; frame[1] = p1; frame[2] = p2; frame[3] = p3;
        frame[4] = p4; frame[5] = p5; frame[6] = p6; frame[7] = p7;
    endtask

    task automatic rand_frame();
        logic signed [PW-1:0] r;
        for (int i = 0; i < NC*NF; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                frame[i] = (longint'($urandom_range(0, 8)) - 4) * 256;
            end else begin
                r = PW'({$urandom(), $urandom()});
                frame[i] = r;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; ce = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sel = 1'b0; in_data = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_class !== '0 ||
            out_score !== '0 || out_sat !== 1'b0) begin
            errs++;
            $display("FAIL reset_values ready=%b valid=%b class=%0d score=%0d sat=%b required 1/0/0/0/0",
                     in_ready, out_valid, out_class, out_score, out_sat);
        end
    endtask

    task automatic test_basic_argmax();
        set_frame(256, 512, -256, -256, 2560, 0, 1280, 1280);
        send_frame(1'b0);
        finish_frame("basic", 1'b0);
        checks++;
        if (cls0 !== 2'd2) begin
            errs++;
            $display("FAIL basic_const_class got=%0d required=2", cls0);
        end
    endtask

    task automatic test_floor_shift();
        set_frame(-1, -1, -512, -512, -512, -512, -512, -512);
        send_frame(1'b0);
        finish_frame("floor", 1'b0);
        checks++;
        if (score0 !== -40'sd2) begin
            errs++;
            $display("FAIL floor_const_score got=%0d required=-2", score0);
        end
    endtask

    task automatic test_back_to_back();
        rand_frame();
        send_frame(1'b0);
        finish_frame("backpressure", 1'b1);
        rand_frame();
        send_frame(1'b0);
        finish_frame("b2b_next", 1'b0);
    endtask

    task automatic test_saturation();
        longint big;
        big = (longint'(1) <<< 34) - 1;
        @(negedge clk);
        sel = 1'b1;
        set_frame(big, big, 0, 0, 0, 0, 0, 0);
        send_frame(1'b0);
        finish_frame("sat", 1'b0);
        rand_frame();
        send_frame(1'b1);
        finish_frame("sat_rand", 1'b0);
        @(negedge clk);
        sel = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        int seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = PW'(longint'(i + 1) * 25600);
        end
        @(negedge clk);
        in_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errs++;
            $display("FAIL reset_mid_no_valid cycles_valid=%0d required=0", seen);
        end
        set_frame(-768, 0, 1024, 256, 512, 512, -5000, 7000);
        send_frame(1'b0);
        finish_frame("reset_mid_clean", 1'b0);
    endtask

    task automatic test_ce_stall();
        for (int n = 0; n < 6; n++) begin
            rand_frame();
            send_frame(1'b0);
            finish_frame("nostall", 1'b0);
            send_frame(1'b1);
            finish_frame("ce_stall", 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_basic_argmax();
        test_floor_shift();
        test_back_to_back();
        test_saturation();
        test_reset_mid_frame();
        test_ce_stall();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
